// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared types, flag indices and helpers for fp_mul_pipe
// Operand classes, exponent bias and canonical quiet-NaN construction for any EXP_W/MAN_W.
package fp_mul_pkg;

   typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp_class_e;

   localparam int INV = 3;
   localparam int OVF = 2;
   localparam int UNF = 1;
   localparam int NX  = 0;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Wide result; callers keep the low 1+exp_w+man_w bits (sign bit is 0).
   function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
      logic [63:0] v;
      v = ((64'd1 << exp_w) - 64'd1) << man_w;
      v = v | (64'd1 << (man_w - 1));
      return v;
   endfunction

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational operand decode: class, hidden-bit mantissa, exponent
// Subnormals are reported as ZERO so the multiplier flushes them.
module fp_classify
   import fp_mul_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic [EXP_W+MAN_W-1:0] i_op,
   output fp_class_e              o_class,
   output logic [MAN_W:0]         o_man,
   output logic [EXP_W-1:0]       o_exp
);

   logic [EXP_W-1:0] w_exp;
   logic [MAN_W-1:0] w_frac;

   assign w_exp  = i_op[EXP_W+MAN_W-1:MAN_W];
   assign w_frac = i_op[MAN_W-1:0];
   assign o_exp  = w_exp;
   assign o_man  = {1'b1, w_frac};

   always_comb begin
      o_class = NORM;
      if (w_exp == '0) begin
         o_class = ZERO;
      end else if (&w_exp) begin
         if (w_frac == '0)
            o_class = INF;
         else if (w_frac[MAN_W-1])
            o_class = QNAN;
         else
            o_class = SNAN;
      end
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - pipelined RNE floating-point multiplier with global-stall backpressure
// Define FP_MUL_FLAGS_EN to add the io_flags port {invalid, overflow, underflow, inexact}.
module fp_mul_pipe
   import fp_mul_pkg::*;
#(
   parameter int EXP_W  = 5,
   parameter int MAN_W  = 10,
   parameter int STAGES = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [EXP_W+MAN_W:0]   io_a,
   input  logic [EXP_W+MAN_W:0]   io_b,
   input  logic                   io_valid_in,
   output logic                   io_ready_in,
   output logic [EXP_W+MAN_W:0]   io_out,
   output logic                   io_valid_out,
   input  logic                   io_ready_out
`ifdef FP_MUL_FLAGS_EN
   ,
   output logic [3:0]             io_flags
`endif
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int PW = 2 * (MAN_W + 1);
   localparam logic signed [EXP_W+1:0] BIAS_S  = (EXP_W+2)'(fp_bias(EXP_W));
   localparam logic signed [EXP_W+1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
   localparam logic [63:0]  NAN64     = fp_canon_nan(EXP_W, MAN_W);
   localparam logic [W-1:0] CANON_NAN = NAN64[W-1:0];

   typedef struct packed {
      logic             vld;
      logic             sign;
      logic             special;
      logic [W-1:0]     spec_val;
`ifdef FP_MUL_FLAGS_EN
      logic             spec_inv;
`endif
      logic [EXP_W+1:0] exp;
      logic [PW-1:0]    prod;
   } stage_t;

   logic              w_adv;
   fp_class_e         w_cls_a, w_cls_b;
   logic [MAN_W:0]    w_man_a, w_man_b;
   logic [EXP_W-1:0]  w_exp_a, w_exp_b;
   logic              w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b, w_inf_zero;
   stage_t            w_s1;
   stage_t            r_st [STAGES-1];
   stage_t            w_last;

   logic                     w_shift, w_guard, w_sticky, w_rnd, w_carry, w_unf, w_ovf;
   logic [MAN_W-1:0]         w_frac_pre, w_frac;
   logic signed [EXP_W+1:0]  w_exp_fin;
   logic [W-1:0]             w_res;
   logic [W-1:0]             r_out;
   logic                     r_vout;
`ifdef FP_MUL_FLAGS_EN
   logic [3:0]               w_flags;
   logic [3:0]               r_flags;
`endif

   // The whole pipe advances together, so one stalled output freezes every stage.
   assign w_adv        = !r_vout || io_ready_out;
   assign io_ready_in  = w_adv;
   assign io_out       = r_out;
   assign io_valid_out = r_vout;
`ifdef FP_MUL_FLAGS_EN
   assign io_flags     = r_flags;
`endif

   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
      .i_op(io_a[W-2:0]), .o_class(w_cls_a), .o_man(w_man_a), .o_exp(w_exp_a)
   );
   fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
      .i_op(io_b[W-2:0]), .o_class(w_cls_b), .o_man(w_man_b), .o_exp(w_exp_b)
   );

   assign w_nan_a    = (w_cls_a == QNAN) || (w_cls_a == SNAN);
   assign w_nan_b    = (w_cls_b == QNAN) || (w_cls_b == SNAN);
   assign w_inf_a    = (w_cls_a == INF);
   assign w_inf_b    = (w_cls_b == INF);
   assign w_zero_a   = (w_cls_a == ZERO);
   assign w_zero_b   = (w_cls_b == ZERO);
   assign w_inf_zero = (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b);

   always_comb begin
      w_s1          = '0;
      w_s1.vld      = io_valid_in;
      w_s1.sign     = io_a[W-1] ^ io_b[W-1];
      w_s1.exp      = $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b}) - BIAS_S;
      w_s1.prod     = PW'(w_man_a) * PW'(w_man_b);
      if (w_nan_a || w_nan_b || w_inf_zero) begin
         w_s1.special  = 1'b1;
         w_s1.spec_val = CANON_NAN;
`ifdef FP_MUL_FLAGS_EN
         w_s1.spec_inv = w_inf_zero || (w_cls_a == SNAN) || (w_cls_b == SNAN);
`endif
      end else if (w_inf_a || w_inf_b) begin
         w_s1.special  = 1'b1;
         w_s1.spec_val = {w_s1.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (w_zero_a || w_zero_b) begin
         w_s1.special  = 1'b1;
         w_s1.spec_val = {w_s1.sign, {(W-1){1'b0}}};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < STAGES-1; i++) r_st[i] <= '0;
      end else if (w_adv) begin
         r_st[0] <= w_s1;
         for (int i = 1; i < STAGES-1; i++) r_st[i] <= r_st[i-1];
      end
   end

   assign w_last = r_st[STAGES-2];

   // Product lies in [1,4): bit PW-1 set means shift right by one before rounding.
   assign w_shift    = w_last.prod[PW-1];
   assign w_frac_pre = w_shift ? w_last.prod[PW-2 -: MAN_W] : w_last.prod[PW-3 -: MAN_W];
   assign w_guard    = w_shift ? w_last.prod[PW-2-MAN_W] : w_last.prod[PW-3-MAN_W];
   assign w_sticky   = w_shift ? |w_last.prod[PW-3-MAN_W:0] : |w_last.prod[PW-4-MAN_W:0];
   assign w_rnd      = w_guard & (w_sticky | w_frac_pre[0]);
   assign {w_carry, w_frac} = {1'b0, w_frac_pre} + {{MAN_W{1'b0}}, w_rnd};
   assign w_exp_fin  = $signed(w_last.exp) + $signed({{(EXP_W+1){1'b0}}, w_shift})
                     + $signed({{(EXP_W+1){1'b0}}, w_carry});
   assign w_unf      = w_exp_fin[EXP_W+1] || (w_exp_fin == '0);
   assign w_ovf      = w_exp_fin >= EXP_MAX;

   always_comb begin
      w_res = {w_last.sign, w_exp_fin[EXP_W-1:0], w_frac};
`ifdef FP_MUL_FLAGS_EN
      w_flags     = '0;
      w_flags[NX] = w_guard | w_sticky;
`endif
      if (w_last.special) begin
         w_res = w_last.spec_val;
`ifdef FP_MUL_FLAGS_EN
         w_flags      = '0;
         w_flags[INV] = w_last.spec_inv;
`endif
      end else if (w_unf) begin
         w_res = {w_last.sign, {(W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
         w_flags      = '0;
         w_flags[UNF] = 1'b1;
         w_flags[NX]  = 1'b1;
`endif
      end else if (w_ovf) begin
         w_res = {w_last.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_MUL_FLAGS_EN
         w_flags      = '0;
         w_flags[OVF] = 1'b1;
         w_flags[NX]  = 1'b1;
`endif
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_out   <= '0;
         r_vout  <= 1'b0;
`ifdef FP_MUL_FLAGS_EN
         r_flags <= '0;
`endif
      end else if (w_adv) begin
         r_out   <= w_res;
         r_vout  <= w_last.vld;
`ifdef FP_MUL_FLAGS_EN
         r_flags <= w_last.vld ? w_flags : 4'b0;
`endif
      end
   end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-style floating-point multiplier; next generation of the fixed fp16 FPMultiply.
- Generic exponent/mantissa widths, configurable pipeline depth, ready/valid backpressure on both sides, round-to-nearest-even, full special-value handling.
- Serves as the multiply stage of the systolic-array processing element (PE), feeding the accumulator.

Parameters:
- EXP_W, 5, exponent field width (fp16=5, bf16=8).
- MAN_W, 10, stored mantissa field width (fp16=10, bf16=7).
- STAGES, 3, pipeline depth in cycles, legal range 2..6.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- io_a  in  1+EXP_W+MAN_W  operand A, packed {sign, exp, man}.
- io_b  in  1+EXP_W+MAN_W  operand B.
- io_valid_in  in  1  operands valid.
- io_ready_in  out  1  block accepts operands this cycle.
- io_out  out  1+EXP_W+MAN_W  product.
- io_valid_out  out  1  product valid.
- io_ready_out  in  1  downstream accepts product.
- io_flags  out  4  {invalid, overflow, underflow, inexact}; present only with FP_MUL_FLAGS_EN.

Behaviour:
- Reset (reset=0, async): all stage valid bits cleared. io_valid_out=0, io_out=0, io_flags=0. io_ready_in=1 once reset is released.
- Global advance: adv = !io_valid_out || io_ready_out. io_ready_in = adv.
  - All stage registers load only when adv=1; otherwise the whole pipe freezes.
- Input is accepted when io_valid_in && io_ready_in. Latency is exactly STAGES cycles of adv=1 from accept to io_valid_out.
  - Back-to-back throughput is 1/cycle.
  - No bubble collapsing; bubbles travel as stage valid=0.
- Held outputs: while io_valid_out=1 and io_ready_out=0, io_out and io_flags stay stable.
- Stage split:
  - S1: unpack, classify, sign = sa^sb, exponent sum ea+eb-BIAS in EXP_W+2 signed bits, mantissa product (MAN_W+1)^2 bits.
  - Middle stages: product register retiming only.
  - Last stage: normalise (product >= 2 → shift right 1, exp+1), RNE round using guard/round/sticky, renormalise on round carry, pack.
- Special cases (priority order):
  - NaN input, or inf*0 → canonical quiet NaN {0, all-ones exp, 1 followed by zeros}; invalid=1 only for inf*0 or a signalling NaN.
  - Inf*finite nonzero → signed infinity.
  - Zero*finite → signed zero.
- Subnormals: subnormal inputs are flushed to signed zero. Result exponent <= 0 after rounding → signed zero with underflow=1 and inexact=1.
- Overflow: exponent >= all-ones → signed infinity, overflow=1, inexact=1.
- Inexact: set when any discarded bit is nonzero.
- Reset asserted mid-operation: all in-flight results are discarded; no partial output.

Optional Feature:
- FP_MUL_FLAGS_EN defined:
  - io_flags port exists and is pipelined alongside data.
  - Flags are valid when io_valid_out=1 and are 0 when io_valid_out=0.
- Not defined:
  - io_flags port is absent and flag logic is removed.
  - Data path is bit-identical to the defined case.

Decomposition:
- Package fp_mul_pkg:
  - BIAS function of EXP_W.
  - Operand class enum {ZERO, NORM, INF, QNAN, SNAN}.
  - Flag bit index constants: INV=3, OVF=2, UNF=1, NX=0.
  - Canonical NaN builder function.
- Sub-module fp_classify: one instance per operand; combinational decode to class, hidden-bit mantissa and exponent.
- Rounding stays inline in fp_mul_pipe.

Test Plan:
- Default params, 0x3e00*0x3e00 with io_ready_out=1 → io_out=0x4080 exactly 3 cycles after accept; flags=0.
- 0x3c01*0x3c01 → 0x3c02 (RNE, inexact=1). 0xbc00*0x3c00 → 0xbc00.
- 0x7bff*0x7bff → 0x7c00 with overflow=1, inexact=1. 0x0400*0x0400 → 0x0000 with underflow=1.
- 0x7c00*0x0000 → 0x7e00 with invalid=1. 0xfc00*0x4000 → 0xfc00, flags=0.
- Stream 8 back-to-back operand pairs with io_ready_out held 0 for cycles 4..7:
  - io_ready_in drops while the output is held.
  - io_out stays stable while held.
  - All 8 results arrive in order, with no loss or duplication.
- Assert reset with 2 operands in flight → io_valid_out=0 immediately; after release, a new operand pair returns the correct result after 3 cycles.
